// File: rtl/iob_native_bus_bridge_pkg.sv
// Shared types for the native-to-IOb bus bridge.
// FSM encoding, error fill bit and channel-select width helper.
package iob_native_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic ERR_FILL = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_bus_watchdog.sv
// Access watchdog: counts enabled cycles, flags the cycle the
// count would reach all-ones.
module iob_bus_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic         expire,
  output logic [W-1:0] count
);

  logic [W-1:0] nxt;

  assign nxt    = count + W'(1);
  assign expire = en && (&nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/iob_native_bus_bridge.sv
// Registered native-port to IOb bridge: one ibus, N_DBUS
// address-decoded dbus channels, timeout watchdog with error capture.
module iob_native_bus_bridge
  import iob_native_bus_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int N_DBUS     = 2,
  parameter int USE_EXTMEM = 0,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cke_i,
  input  logic                     boot_i,
  input  logic                     cpu_valid_i,
  input  logic                     cpu_instr_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [DATA_W-1:0]        cpu_wdata_i,
  input  logic [DATA_W/8-1:0]      cpu_wstrb_i,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     cpu_ready_o,
  output logic                     ibus_iob_valid_o,
  output logic [ADDR_W-1:0]        ibus_iob_addr_o,
  output logic [DATA_W-1:0]        ibus_iob_wdata_o,
  output logic [DATA_W/8-1:0]      ibus_iob_wstrb_o,
  input  logic [DATA_W-1:0]        ibus_iob_rdata_i,
  input  logic                     ibus_iob_rvalid_i,
  input  logic                     ibus_iob_ready_i,
  output logic [N_DBUS-1:0]        dbus_iob_valid_o,
  output logic [ADDR_W-1:0]        dbus_iob_addr_o,
  output logic [DATA_W-1:0]        dbus_iob_wdata_o,
  output logic [DATA_W/8-1:0]      dbus_iob_wstrb_o,
  input  logic [N_DBUS*DATA_W-1:0] dbus_iob_rdata_i,
  input  logic [N_DBUS-1:0]        dbus_iob_rvalid_i,
  input  logic [N_DBUS-1:0]        dbus_iob_ready_i,
  output logic                     err_o,
  output logic [ADDR_W-1:0]        err_addr_o,
  input  logic                     err_clr_i
);

  localparam int SEL_W  = sel_width(N_DBUS);
  localparam int STRB_W = DATA_W / 8;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                instr_q;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_d;
  logic                t_ready;
  logic                t_rvalid;
  logic [DATA_W-1:0]   t_rdata;
  logic                wr;
  logic                done;
  logic                abort;
  logic                wd_clr;
  logic                wd_en;
  logic                wd_exp;
  logic [TIMEOUT_W-1:0] wd_cnt;

  if (N_DBUS > 1) begin : g_sel
    assign sel_d = cpu_addr_i[ADDR_W-1 -: SEL_W];
  end else begin : g_sel1
    assign sel_d = '0;
  end

  if (USE_EXTMEM != 0) begin : g_ext
    assign ibus_iob_addr_o = {~boot_i, addr_q[ADDR_W-2:0]};
  end else begin : g_noext
    logic unused_boot;
    assign unused_boot     = boot_i;
    assign ibus_iob_addr_o = addr_q;
  end

  assign ibus_iob_wdata_o = '0;
  assign ibus_iob_wstrb_o = '0;
  assign dbus_iob_addr_o  = addr_q;
  assign dbus_iob_wdata_o = wdata_q;
  assign dbus_iob_wstrb_o = wstrb_q;

  // Only the captured target's response is ever looked at.
  always_comb begin
    t_ready  = ibus_iob_ready_i;
    t_rvalid = ibus_iob_rvalid_i;
    t_rdata  = ibus_iob_rdata_i;
    if (!instr_q) begin
      t_ready  = 1'b0;
      t_rvalid = 1'b0;
      t_rdata  = '0;
      for (int k = 0; k < N_DBUS; k++) begin
        if (sel_q == SEL_W'(k)) begin
          t_ready  = dbus_iob_ready_i[k];
          t_rvalid = dbus_iob_rvalid_i[k];
          t_rdata  = dbus_iob_rdata_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign wr   = |wstrb_q;
  assign done = (state == REQ && t_ready && (wr || t_rvalid))
             || (state == WAIT && t_rvalid);
  // A completion in the expiring cycle wins over the abort.
  assign abort  = wd_exp && !done;
  assign wd_clr = cke_i && (state == IDLE) && cpu_valid_i;
  assign wd_en  = cke_i && (state == REQ || state == WAIT);

  iob_bus_watchdog #(
    .W(TIMEOUT_W)
  ) u_wd (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_exp),
    .count  (wd_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      instr_q          <= 1'b0;
      sel_q            <= '0;
      cpu_rdata_o      <= '0;
      cpu_ready_o      <= 1'b0;
      ibus_iob_valid_o <= 1'b0;
      dbus_iob_valid_o <= '0;
    end else if (cke_i) begin
      cpu_ready_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_valid_i) begin
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            wstrb_q <= cpu_wstrb_i;
            instr_q <= cpu_instr_i;
            sel_q   <= sel_d;
            state   <= REQ;
            if (cpu_instr_i) ibus_iob_valid_o <= 1'b1;
            else dbus_iob_valid_o <= N_DBUS'(1) << sel_d;
          end
        end
        REQ: begin
          if (done) begin
            cpu_rdata_o      <= wr ? '0 : t_rdata;
            cpu_ready_o      <= 1'b1;
            ibus_iob_valid_o <= 1'b0;
            dbus_iob_valid_o <= '0;
            state            <= RESP;
          end else if (abort) begin
            cpu_rdata_o      <= {DATA_W{ERR_FILL}};
            cpu_ready_o      <= 1'b1;
            ibus_iob_valid_o <= 1'b0;
            dbus_iob_valid_o <= '0;
            state            <= RESP;
          end else if (t_ready) begin
            ibus_iob_valid_o <= 1'b0;
            dbus_iob_valid_o <= '0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            cpu_rdata_o <= t_rdata;
            cpu_ready_o <= 1'b1;
            state       <= RESP;
          end else if (abort) begin
            cpu_rdata_o <= {DATA_W{ERR_FILL}};
            cpu_ready_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (cke_i) begin
      if (err_clr_i) begin
        err_o      <= 1'b0;
        err_addr_o <= '0;
      end else if (abort) begin
        err_o <= 1'b1;
        if (!err_o) err_addr_o <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_iob_native_bus_bridge.sv
// Directed bench for iob_native_bus_bridge: vector table of single
// accesses plus timeout, reset-in-flight and clock-enable sequences.
module tb_iob_native_bus_bridge;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cke_i;
  logic         boot_i;
  logic         cpu_valid_i;
  logic         cpu_instr_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [3:0]   cpu_wstrb_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_ready_o;
  logic         ibus_iob_valid_o;
  logic [31:0]  ibus_iob_addr_o;
  logic [31:0]  ibus_iob_wdata_o;
  logic [3:0]   ibus_iob_wstrb_o;
  logic [31:0]  ibus_iob_rdata_i;
  logic         ibus_iob_rvalid_i;
  logic         ibus_iob_ready_i;
  logic [3:0]   dbus_iob_valid_o;
  logic [31:0]  dbus_iob_addr_o;
  logic [31:0]  dbus_iob_wdata_o;
  logic [3:0]   dbus_iob_wstrb_o;
  logic [127:0] dbus_iob_rdata_i;
  logic [3:0]   dbus_iob_rvalid_i;
  logic [3:0]   dbus_iob_ready_i;
  logic         err_o;
  logic [31:0]  err_addr_o;
  logic         err_clr_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_native_bus_bridge #(
    .ADDR_W(32), .DATA_W(32), .N_DBUS(4),
    .USE_EXTMEM(1), .TIMEOUT_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i), .boot_i(boot_i),
    .cpu_valid_i(cpu_valid_i), .cpu_instr_i(cpu_instr_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_wstrb_i(cpu_wstrb_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_ready_o(cpu_ready_o),
    .ibus_iob_valid_o(ibus_iob_valid_o),
    .ibus_iob_addr_o(ibus_iob_addr_o),
    .ibus_iob_wdata_o(ibus_iob_wdata_o),
    .ibus_iob_wstrb_o(ibus_iob_wstrb_o),
    .ibus_iob_rdata_i(ibus_iob_rdata_i),
    .ibus_iob_rvalid_i(ibus_iob_rvalid_i),
    .ibus_iob_ready_i(ibus_iob_ready_i),
    .dbus_iob_valid_o(dbus_iob_valid_o),
    .dbus_iob_addr_o(dbus_iob_addr_o),
    .dbus_iob_wdata_o(dbus_iob_wdata_o),
    .dbus_iob_wstrb_o(dbus_iob_wstrb_o),
    .dbus_iob_rdata_i(dbus_iob_rdata_i),
    .dbus_iob_rvalid_i(dbus_iob_rvalid_i),
    .dbus_iob_ready_i(dbus_iob_ready_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  typedef struct {
    bit          instr;
    bit          boot;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          d;
    int          r;
    logic [31:0] rdata;
    bit          exp_iv;
    logic [3:0]  exp_dv;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-target buses always answer with junk so any leak shows.
  task automatic set_bus(input bit instr, input int ch, input logic rdy,
                         input logic rv, input logic [31:0] data);
    ibus_iob_ready_i  = 1'b1;
    ibus_iob_rvalid_i = 1'b1;
    ibus_iob_rdata_i  = 32'hBAD0_00FF;
    for (int k = 0; k < 4; k++) begin
      dbus_iob_ready_i[k]          = 1'b1;
      dbus_iob_rvalid_i[k]         = 1'b1;
      dbus_iob_rdata_i[k*32 +: 32] = 32'hBAD0_0000 | k;
    end
    if (instr) begin
      ibus_iob_ready_i  = rdy;
      ibus_iob_rvalid_i = rv;
      ibus_iob_rdata_i  = data;
    end else begin
      dbus_iob_ready_i[ch]          = rdy;
      dbus_iob_rvalid_i[ch]         = rv;
      dbus_iob_rdata_i[ch*32 +: 32] = data;
    end
  endtask

  task automatic do_access(input vec_t v, output int lat,
                           output logic [31:0] rd, output logic iv,
                           output logic [3:0] dv, output logic [31:0] baddr,
                           output logic [3:0] bw);
    int ch;
    logic rdy, rv;
    ch = int'(v.addr[31:30]);
    set_bus(v.instr, ch, 1'b0, 1'b0, v.rdata);
    boot_i      = v.boot;
    cpu_valid_i = 1'b1;
    cpu_instr_i = v.instr;
    cpu_addr_i  = v.addr;
    cpu_wdata_i = v.wdata;
    cpu_wstrb_i = v.wstrb;
    tick();
    cpu_valid_i = 1'b0;
    iv    = ibus_iob_valid_o;
    dv    = dbus_iob_valid_o;
    baddr = v.instr ? ibus_iob_addr_o : dbus_iob_addr_o;
    bw    = dbus_iob_wstrb_o;
    lat   = -1;
    rd    = 'x;
    for (int c = 1; c < 400; c++) begin
      rdy = (c == 1 + v.d);
      rv  = (v.wstrb == 4'h0) && (c == 1 + v.d + v.r);
      set_bus(v.instr, ch, rdy, rv, v.rdata);
      tick();
      if (cpu_ready_o) begin
        lat = c + 1;
        rd  = cpu_rdata_o;
        break;
      end
    end
    set_bus(v.instr, ch, 1'b0, 1'b0, v.rdata);
  endtask

  int          lat;
  logic [31:0] rd, baddr;
  logic        iv;
  logic [3:0]  dv, bw;
  vec_t        t;

  initial begin
    //        instr boot addr          wstrb wdata         d     r  rdata         iv dv      lat rd            addr
    vecs[0] = '{1, 1, 32'h0000_0100, 4'h0, 32'h0,        0,    1, 32'h0000_0013, 1, 4'b0000, 3, 32'h0000_0013, 32'h0000_0100};
    vecs[1] = '{0, 1, 32'hC000_0010, 4'hF, 32'hDEAD_BEEF, 0,   0, 32'h1234_5678, 0, 4'b1000, 2, 32'h0,         32'hC000_0010};
    vecs[2] = '{0, 1, 32'h4000_0000, 4'h0, 32'h0,        0,    0, 32'h1111_1111, 0, 4'b0010, 2, 32'h1111_1111, 32'h4000_0000};
    vecs[3] = '{0, 1, 32'h8000_0004, 4'h0, 32'h0,        2,    3, 32'h2222_2222, 0, 4'b0100, 7, 32'h2222_2222, 32'h8000_0004};
    vecs[4] = '{0, 1, 32'h0000_0008, 4'h0, 32'h0,        1,    0, 32'h0A0A_0A0A, 0, 4'b0001, 3, 32'h0A0A_0A0A, 32'h0000_0008};
    vecs[5] = '{1, 1, 32'h0000_0200, 4'h0, 32'h0,        0,    0, 32'h0000_0093, 1, 4'b0000, 2, 32'h0000_0093, 32'h0000_0200};
    vecs[6] = '{0, 1, 32'h4000_0020, 4'h3, 32'h0000_BEEF, 3,   0, 32'h5555_5555, 0, 4'b0010, 5, 32'h0,         32'h4000_0020};
    vecs[7] = '{1, 1, 32'h0000_0040, 4'h0, 32'h0,        0,    0, 32'h0000_0037, 1, 4'b0000, 2, 32'h0000_0037, 32'h0000_0040};
    vecs[8] = '{1, 0, 32'h0000_0040, 4'h0, 32'h0,        0,    2, 32'h0000_0073, 1, 4'b0000, 4, 32'h0000_0073, 32'h8000_0040};

    rst_i = 1'b1; cke_i = 1'b1; boot_i = 1'b1; err_clr_i = 1'b0;
    cpu_valid_i = 1'b0; cpu_instr_i = 1'b0; cpu_addr_i = '0;
    cpu_wdata_i = '0; cpu_wstrb_i = '0;
    set_bus(1'b1, 0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_ready", 64'(cpu_ready_o), 64'h0);
    chk("rst_rdata", 64'(cpu_rdata_o), 64'h0);
    chk("rst_ivalid", 64'(ibus_iob_valid_o), 64'h0);
    chk("rst_iaddr", 64'(ibus_iob_addr_o), 64'h0);
    chk("rst_dvalid", 64'(dbus_iob_valid_o), 64'h0);
    chk("rst_daddr", 64'(dbus_iob_addr_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_erraddr", 64'(err_addr_o), 64'h0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i], lat, rd, iv, dv, baddr, bw);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_ivalid", i), 64'(iv), 64'(vecs[i].exp_iv));
      chk($sformatf("v%0d_dvalid", i), 64'(dv), 64'(vecs[i].exp_dv));
      chk($sformatf("v%0d_addr", i), 64'(baddr), 64'(vecs[i].exp_addr));
      if (!vecs[i].instr)
        chk($sformatf("v%0d_wstrb", i), 64'(bw), 64'(vecs[i].wstrb));
      tick();
      chk($sformatf("v%0d_pulse", i), 64'(cpu_ready_o), 64'h0);
    end

    // Timeout: ready never comes; abort after 255 REQ cycles.
    t = '{0, 1, 32'h4000_0100, 4'h0, 32'h0, 99999, 0, 32'h0, 0, 4'b0010, 256, 32'hFFFF_FFFF, 32'h4000_0100};
    do_access(t, lat, rd, iv, dv, baddr, bw);
    chk("to1_lat", 64'(lat), 64'd256);
    chk("to1_rdata", 64'(rd), 64'hFFFF_FFFF);
    chk("to1_err", 64'(err_o), 64'h1);
    chk("to1_erraddr", 64'(err_addr_o), 64'h4000_0100);
    tick();
    t.addr = 32'h8000_0200;
    do_access(t, lat, rd, iv, dv, baddr, bw);
    chk("to2_lat", 64'(lat), 64'd256);
    chk("to2_rdata", 64'(rd), 64'hFFFF_FFFF);
    chk("to2_err", 64'(err_o), 64'h1);
    chk("to2_erraddr", 64'(err_addr_o), 64'h4000_0100);
    tick();

    // Reset while waiting for rvalid; late rvalid is dropped.
    boot_i = 1'b1;
    set_bus(1'b1, 0, 1'b0, 1'b0, 32'h55);
    cpu_valid_i = 1'b1; cpu_instr_i = 1'b1;
    cpu_addr_i = 32'h0000_0300; cpu_wstrb_i = 4'h0;
    tick();
    cpu_valid_i = 1'b0;
    set_bus(1'b1, 0, 1'b1, 1'b0, 32'h55);
    tick();
    set_bus(1'b1, 0, 1'b0, 1'b0, 32'h55);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rw_ready", 64'(cpu_ready_o), 64'h0);
    chk("rw_rdata", 64'(cpu_rdata_o), 64'h0);
    chk("rw_ivalid", 64'(ibus_iob_valid_o), 64'h0);
    chk("rw_iaddr", 64'(ibus_iob_addr_o), 64'h0);
    chk("rw_err", 64'(err_o), 64'h0);
    chk("rw_erraddr", 64'(err_addr_o), 64'h0);
    set_bus(1'b1, 0, 1'b0, 1'b1, 32'h55);
    tick();
    set_bus(1'b1, 0, 1'b0, 1'b0, 32'h55);
    chk("rw_late1", 64'(cpu_ready_o), 64'h0);
    tick();
    chk("rw_late2", 64'(cpu_ready_o), 64'h0);
    tick();

    // Clock enable low for 5 cycles in REQ: everything freezes.
    set_bus(1'b0, 0, 1'b0, 1'b0, 32'hC0FF_EE00);
    cpu_valid_i = 1'b1; cpu_instr_i = 1'b0;
    cpu_addr_i = 32'h0000_0008; cpu_wstrb_i = 4'h0;
    tick();
    cpu_valid_i = 1'b0;
    tick(); tick();
    chk("cke_cnt0", 64'(dut.u_wd.count), 64'd2);
    cke_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("cke_dv%0d", k), 64'(dbus_iob_valid_o), 64'h1);
      chk($sformatf("cke_cnt%0d", k + 1), 64'(dut.u_wd.count), 64'd2);
    end
    cke_i = 1'b1;
    lat = -1;
    for (int c = 8; c < 60; c++) begin
      set_bus(1'b0, 0, c == 16, c == 16, 32'hC0FF_EE00);
      tick();
      if (cpu_ready_o) begin
        lat = c + 1;
        break;
      end
    end
    set_bus(1'b0, 0, 1'b0, 1'b0, 32'h0);
    chk("cke_lat", 64'(lat), 64'd17);
    chk("cke_rdata", 64'(cpu_rdata_o), 64'hC0FF_EE00);
    tick();

    // Fresh error after reset captures its address; clear wipes it.
    t.addr = 32'h0000_0500;
    do_access(t, lat, rd, iv, dv, baddr, bw);
    chk("to3_lat", 64'(lat), 64'd256);
    chk("to3_erraddr", 64'(err_addr_o), 64'h0000_0500);
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("clr_err", 64'(err_o), 64'h0);
    chk("clr_erraddr", 64'(err_addr_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
